// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multicycle CPU datapath. One instruction is sequenced at a
//   time. The FSM reads the decoder opcode and the ALU zero flag, and it drives
//   every datapath strobe. Outputs are decoded from the current state (Moore),
//   with one exception: pc_write in BRANCH also depends on alu_zero.
//   Illegal opcodes and HALT park the FSM in HALT until reset. A counter tracks
//   retired instructions.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   allow the next fetch; sampled in IDLE and retire states
//   opcode[5:0]           opcode from the instruction decoder
//   alu_zero              ALU zero flag
//   select_ins            IorD (0 = PC, 1 = ALU output)
//   reg_write, reg_dst    register-file write enable, destination (0 = Rt, 1 = Rd)
//   alu_src_a, alu_src_b  ALU operand selects
//   mem_write, mem_to_reg data-memory write enable, write-back source
//   beq                   branch sense (1 = on zero, 0 = on not-zero)
//   pc_src, pc_write      PC source select, PC load enable
//   ir_write              instruction-register load enable
//   state[3:0]            current state, for debug
//   halted                high in HALT
//   instr_count           retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] OP_LW   = 6'b100000,
  parameter logic [5:0] OP_SW   = 6'b100001,
  parameter logic [5:0] OP_BEQ  = 6'b110000,
  parameter logic [5:0] OP_BNE  = 6'b110001,
  parameter logic [5:0] OP_JMP  = 6'b110010,
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  output logic             select_ins,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             beq,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_is_rtype;
  logic             w_beq_op;
  logic             w_taken;

  // The R-type/I-type distinction is carried from DECODE to ALU_WB through
  // op_q, because the opcode input is not guaranteed to hold steady.
  assign w_is_rtype = (r_op_q[5:4] == 2'b00);
  assign w_beq_op   = (r_op_q == OP_BEQ);
  assign w_taken    = w_beq_op ? alu_zero : ~alu_zero;

  // Each retire state lasts exactly one cycle, so counting in the retire
  // state counts the transition out of it.
  assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                    (r_state == S_MEM_WR) || (r_state == S_BRANCH) ||
                    (r_state == S_JUMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_q  <= 6'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    select_ins = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    beq        = 1'b0;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IDLE: w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        if (opcode[5:4] == 2'b00)                     w_next = S_EXEC_R;
        else if (opcode[5:4] == 2'b01)                w_next = S_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)  w_next = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) w_next = S_BRANCH;
        else if (opcode == OP_JMP)                    w_next = S_JUMP;
        else                                          w_next = S_HALT;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: w_next = S_MEM_WB;
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = run ? S_FETCH : S_IDLE;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = w_is_rtype;
        alu_src_a = 1'b1;
        alu_src_b = w_is_rtype ? 2'b00 : 2'b10;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b10;
        beq       = w_beq_op;
        pc_write  = w_taken;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        w_next   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_HALT;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        alu_zero;

  logic        select_ins, reg_write, reg_dst, alu_src_a, mem_write, mem_to_reg;
  logic        beq, pc_write, ir_write, halted;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        s_select_ins, s_reg_write, s_reg_dst, s_alu_src_a, s_mem_write, s_mem_to_reg;
  logic        s_beq, s_pc_write, s_ir_write, s_halted;
  logic [1:0]  s_alu_src_b, s_pc_src;
  logic [3:0]  s_state;
  logic [3:0]  s_instr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .select_ins(select_ins), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .beq(beq), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .state(state), .halted(halted), .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .select_ins(s_select_ins), .reg_write(s_reg_write), .reg_dst(s_reg_dst),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .mem_write(s_mem_write),
    .mem_to_reg(s_mem_to_reg), .beq(s_beq), .pc_src(s_pc_src), .pc_write(s_pc_write),
    .ir_write(s_ir_write), .state(s_state), .halted(s_halted), .instr_count(s_instr_count)
  );

  // Strobe bundle: sel rw rd asa asb[1:0] mw mtr beq pcs[1:0] pcw irw
  function automatic logic [12:0] strobes();
    return {select_ins, reg_write, reg_dst, alu_src_a, alu_src_b, mem_write,
            mem_to_reg, beq, pc_src, pc_write, ir_write};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 6'h00; alu_zero = 1'b0;
    #12;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_strobes", {19'd0, strobes()}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_count", instr_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("idle_hold", {28'd0, state}, 32'd0);

    // T1: R-type
    run = 1'b1; opcode = 6'h02;
    step(); chk("t1_fetch_state", {28'd0, state}, 32'd1);
    chk("t1_fetch_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_0_01_0_0_0_00_1_1});
    step(); chk("t1_decode_state", {28'd0, state}, 32'd2);
    chk("t1_decode_strobes", {19'd0, strobes()}, 32'd0);
    step(); chk("t1_execr_state", {28'd0, state}, 32'd3);
    chk("t1_execr_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_1_00_0_0_0_00_0_0});
    step(); chk("t1_aluwb_state", {28'd0, state}, 32'd9);
    chk("t1_aluwb_strobes", {19'd0, strobes()}, {19'd0, 13'b0_1_1_1_00_0_0_0_00_0_0});
    chk("t1_count_before", instr_count, 32'd0);
    step(); chk("t1_refetch_state", {28'd0, state}, 32'd1);
    chk("t1_count", instr_count, 32'd1);

    // T2: LW then SW
    opcode = 6'b100000;
    step(); chk("t2_lw_decode", {28'd0, state}, 32'd2);
    step(); chk("t2_lw_addr", {28'd0, state}, 32'd5);
    chk("t2_lw_addr_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_1_10_0_0_0_00_0_0});
    step(); chk("t2_lw_rd", {28'd0, state}, 32'd6);
    chk("t2_lw_rd_strobes", {19'd0, strobes()}, 32'd0);
    step(); chk("t2_lw_wb", {28'd0, state}, 32'd7);
    chk("t2_lw_wb_strobes", {19'd0, strobes()}, {19'd0, 13'b0_1_0_0_00_0_1_0_00_0_0});
    step(); chk("t2_lw_done", {28'd0, state}, 32'd1);
    chk("t2_count_lw", instr_count, 32'd2);
    opcode = 6'b100001;
    step(); chk("t2_sw_decode", {28'd0, state}, 32'd2);
    step(); chk("t2_sw_addr", {28'd0, state}, 32'd5);
    step(); chk("t2_sw_wr", {28'd0, state}, 32'd8);
    chk("t2_sw_wr_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_0_00_1_0_0_00_0_0});
    step(); chk("t2_sw_done", {28'd0, state}, 32'd1);
    chk("t2_sw_mw_drop", {31'd0, mem_write}, 32'd0);
    chk("t2_count_sw", instr_count, 32'd3);

    // T3: BEQ not taken, BNE taken
    opcode = 6'b110000; alu_zero = 1'b0;
    step(); step(); chk("t3_beq_state", {28'd0, state}, 32'd10);
    chk("t3_beq_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_1_00_0_0_1_10_0_0});
    alu_zero = 1'b1; #1;
    chk("t3_beq_mealy_taken", {31'd0, pc_write}, 32'd1);
    alu_zero = 1'b0;
    step(); chk("t3_beq_done", {28'd0, state}, 32'd1);
    chk("t3_count_beq", instr_count, 32'd4);
    opcode = 6'b110001;
    step(); step(); chk("t3_bne_state", {28'd0, state}, 32'd10);
    chk("t3_bne_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_1_00_0_0_0_10_1_0});
    step(); chk("t3_bne_done", {28'd0, state}, 32'd1);
    chk("t3_count_bne", instr_count, 32'd5);

    // T4: run dropped during EXEC_I
    opcode = 6'h12;
    step(); step(); chk("t4_execi_state", {28'd0, state}, 32'd4);
    chk("t4_execi_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_1_10_0_0_0_00_0_0});
    run = 1'b0;
    step(); chk("t4_aluwb_state", {28'd0, state}, 32'd9);
    chk("t4_aluwb_strobes", {19'd0, strobes()}, {19'd0, 13'b0_1_0_1_10_0_0_0_00_0_0});
    step(); chk("t4_idle", {28'd0, state}, 32'd0);
    chk("t4_count", instr_count, 32'd6);
    step(); step(); chk("t4_idle_hold", {28'd0, state}, 32'd0);
    chk("t4_count_hold", instr_count, 32'd6);
    run = 1'b1;
    step(); chk("t4_resume", {28'd0, state}, 32'd1);

    // T5: illegal opcode halts
    opcode = 6'b101010;
    step(); step(); chk("t5_halt_state", {28'd0, state}, 32'd12);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    opcode = 6'h02;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_halt_hold", {27'd0, halted, state}, {27'd0, 1'b1, 4'd12});
      chk("t5_halt_strobes", {19'd0, strobes()}, 32'd0);
    end
    chk("t5_count", instr_count, 32'd6);

    // T6: async reset mid MEM_WR, then counter wrap
    rst_n = 1'b0; #2; rst_n = 1'b1;
    chk("t6_reset_from_halt", {28'd0, state}, 32'd0);
    opcode = 6'b110010;
    step(); step(); step();
    chk("t6_jump_strobes", {19'd0, strobes()}, {19'd0, 13'b0_0_0_0_00_0_0_0_10_1_0});
    opcode = 6'b100001;
    step(); chk("t6_count_jmp", instr_count, 32'd1);
    step(); step(); step();
    chk("t6_memwr", {28'd0, state}, 32'd8);
    chk("t6_memwr_mw", {31'd0, mem_write}, 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("t6_async_mw", {31'd0, mem_write}, 32'd0);
    chk("t6_async_state", {28'd0, state}, 32'd0);
    chk("t6_async_count", instr_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    opcode = 6'b110010;
    step(); chk("t6_wrap_start", {28'd0, state}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      step(); step(); step();
    end
    chk("t6_wrap_state", {28'd0, state}, 32'd1);
    chk("t6_count_17", instr_count, 32'd17);
    chk("t6_wrap_cnt4", {28'd0, s_instr_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
